morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder_if.sv | 26 ++
 rtl/morse_decoder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_morse_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Morse decoder bundle: raw key in, decoded character stream and status out.
interface morse_decoder_if;
    logic       key_n;
    logic [7:0] ascii_char;
    logic       char_valid;
    logic       key_down;
    logic [2:0] elem_count;

    // Key source / character consumer side
    modport master (
        output key_n,
        input  ascii_char,
        input  char_valid,
        input  key_down,
        input  elem_count
    );

    // Decoder side
    modport slave (
        input  key_n,
        output ascii_char,
        output char_valid,
        output key_down,
        output elem_count
    );
endinterface

// File: rtl/morse_decoder.sv
// Morse key decoder: synchronize and debounce the key, time presses and gaps
// in units of UNIT_CYCLES, and emit one ASCII character per letter plus one
// space per word gap.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES     = 5_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic            clk,
    input  logic            reset,
    morse_decoder_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(7 * UNIT_CYCLES + 1);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned MAX_ELEM = 5;

    localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_END = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_END   = CNT_W'(7 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_MAX    = CNT_W'(7 * UNIT_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS     = 2'd1,
        S_GAP       = 2'd2,
        S_WORD_WAIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_key_sync;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_key_down;

    logic [CNT_W-1:0] r_press_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    // Element code with a leading marker bit: dot=0, dash=1, first element highest
    logic [5:0]       r_code;
    logic [2:0]       r_elem_cnt;
    logic             r_ovf;

    logic [7:0]       r_ascii;
    logic             r_char_valid;

    logic             w_press_clr;
    logic             w_press_inc;
    logic             w_gap_clr;
    logic             w_gap_inc;
    logic             w_append;
    logic             w_letter_clr;
    logic             w_emit_char;
    logic             w_emit_space;
    logic             w_is_dash;
    logic [7:0]       w_lookup;

    // Map a marker-prefixed element code to its uppercase ASCII character
    function automatic logic [7:0] f_lookup(input logic [5:0] code);
        logic [7:0] ch;
        case (code)
            6'd2:  ch = "E";
            6'd3:  ch = "T";
            6'd4:  ch = "I";
            6'd5:  ch = "A";
            6'd6:  ch = "N";
            6'd7:  ch = "M";
            6'd8:  ch = "S";
            6'd9:  ch = "U";
            6'd10: ch = "R";
            6'd11: ch = "W";
            6'd12: ch = "D";
            6'd13: ch = "K";
            6'd14: ch = "G";
            6'd15: ch = "O";
            6'd16: ch = "H";
            6'd17: ch = "V";
            6'd18: ch = "F";
            6'd20: ch = "L";
            6'd22: ch = "P";
            6'd23: ch = "J";
            6'd24: ch = "B";
            6'd25: ch = "X";
            6'd26: ch = "C";
            6'd27: ch = "Y";
            6'd28: ch = "Z";
            6'd29: ch = "Q";
            6'd32: ch = "5";
            6'd33: ch = "4";
            6'd35: ch = "3";
            6'd39: ch = "2";
            6'd47: ch = "1";
            6'd48: ch = "6";
            6'd56: ch = "7";
            6'd60: ch = "8";
            6'd62: ch = "9";
            6'd63: ch = "0";
            default: ch = "?";
        endcase
        return ch;
    endfunction

    // Two-flop synchronizer for the asynchronous key, idles released
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_sync = ~r_sync2;

    // Debounce: accept a new key level only after it persists for the full window
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_key_down <= 1'b0;
        end else if (w_key_sync != r_key_down) begin
            if (r_db_cnt == DB_LAST) begin
                r_key_down <= w_key_sync;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_key_down) w_next_state = S_PRESS;
            end
            S_PRESS: begin
                if (!r_key_down) w_next_state = S_GAP;
            end
            S_GAP: begin
                if (r_key_down)                    w_next_state = S_PRESS;
                else if (r_gap_cnt >= LETTER_END)  w_next_state = S_WORD_WAIT;
            end
            S_WORD_WAIT: begin
                if (r_key_down)                    w_next_state = S_PRESS;
                else if (r_gap_cnt >= WORD_END)    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output logic: counter controls, element append and emission strobes
    always_comb begin
        w_press_clr  = 1'b0;
        w_press_inc  = 1'b0;
        w_gap_clr    = 1'b0;
        w_gap_inc    = 1'b0;
        w_append     = 1'b0;
        w_letter_clr = 1'b0;
        w_emit_char  = 1'b0;
        w_emit_space = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_key_down) w_press_clr = 1'b1;
            end
            S_PRESS: begin
                if (r_key_down) begin
                    w_press_inc = 1'b1;
                end else begin
                    w_append  = 1'b1;
                    w_gap_clr = 1'b1;
                end
            end
            S_GAP: begin
                if (r_key_down) begin
                    w_press_clr = 1'b1;
                end else begin
                    w_gap_inc = 1'b1;
                    if (r_gap_cnt >= LETTER_END) begin
                        w_emit_char  = 1'b1;
                        w_letter_clr = 1'b1;
                    end
                end
            end
            S_WORD_WAIT: begin
                if (r_key_down) begin
                    w_press_clr = 1'b1;
                end else if (r_gap_cnt >= WORD_END) begin
                    w_emit_space = 1'b1;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_is_dash = (r_press_cnt >= DASH_MIN);
    assign w_lookup  = r_ovf ? 8'h3F : f_lookup(r_code);

    // Press and gap duration counters, both saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (w_press_clr) begin
                r_press_cnt <= '0;
            end else if (w_press_inc && (r_press_cnt != DASH_MIN)) begin
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (w_gap_inc && (r_gap_cnt != GAP_MAX)) begin
                r_gap_cnt <= r_gap_cnt + CNT_W'(1);
            end
        end
    end

    // Element store: shift in dots/dashes, flag letters longer than five elements
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code     <= 6'd1;
            r_elem_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_letter_clr) begin
            r_code     <= 6'd1;
            r_elem_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_append) begin
            if (r_elem_cnt == 3'(MAX_ELEM)) begin
                r_ovf <= 1'b1;
            end else begin
                r_code     <= {r_code[4:0], w_is_dash};
                r_elem_cnt <= r_elem_cnt + 3'd1;
            end
        end
    end

    // Character output register: one-cycle valid, character held between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ascii      <= 8'h00;
            r_char_valid <= 1'b0;
        end else begin
            r_char_valid <= w_emit_char | w_emit_space;
            if (w_emit_char) begin
                r_ascii <= w_lookup;
            end else if (w_emit_space) begin
                r_ascii <= 8'h20;
            end
        end
    end

    assign bus.ascii_char = r_ascii;
    assign bus.char_valid = r_char_valid;
    assign bus.key_down   = r_key_down;
    assign bus.elem_count = r_elem_cnt;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed and randomized checks of morse_decoder against a text-level Morse model.
module tb_morse_decoder;

    localparam int unsigned U  = 10;
    localparam int unsigned DB = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   cv_in_reset;
    int   kd_seen;

    byte  got   [$];
    int   got_t [$];
    byte  exp_q [$];

    // Morse alphabet by symbol; the last two entries are an unassigned code and an overlong letter
    string morse_tab [0:37] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        "..--", "......"
    };

    morse_decoder_if bus ();

    morse_decoder #(
        .UNIT_CYCLES     (U),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.char_valid) begin
            got.push_back(byte'(bus.ascii_char));
            got_t.push_back(cyc);
            if (reset) cv_in_reset <= cv_in_reset + 1;
        end
        if (bus.key_down) kd_seen <= kd_seen + 1;
    end

    function automatic byte sym_char(input int idx);
        if (idx < 26)      return byte'(8'h41 + idx);
        else if (idx < 36) return byte'(8'h30 + idx - 26);
        else               return byte'(8'h3F);
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic press(input int n);
        bus.key_n = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_key(input int n);
        bus.key_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Key one symbol with random element timings well clear of the dot/dash threshold
    task automatic send_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            if (p[i] == "-") press(int'($urandom_range(25, 40)));
            else             press(int'($urandom_range(5, 12)));
            if (i != p.len() - 1) release_key(int'($urandom_range(6, 20)));
        end
    endtask

    // Compare captured characters against the model and enforce minimum pulse spacing
    task automatic check_stream(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_char"}, int'(got[i]), int'(exp_q[i]));
        for (int i = 1; i < got_t.size(); i++)
            check({tag, "_spacing_ok"}, int'((got_t[i] - got_t[i-1]) >= int'(4 * U)), 1);
        got.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int nl;
        int idx;
        n_vec = 0; n_err = 0; cyc = 0; cv_in_reset = 0; kd_seen = 0;
        bus.key_n = 1'b0;
        reset = 1'b1;

        // Reset with the key held: everything idle, no character strobe
        repeat (3) @(negedge clk);
        check("rst_ascii", int'(bus.ascii_char), 0);
        check("rst_valid", int'(bus.char_valid), 0);
        check("rst_key_down", int'(bus.key_down), 0);
        check("rst_elem_count", int'(bus.elem_count), 0);
        check("rst_no_pulse", cv_in_reset, 0);

        // Key still held after reset release counts as a fresh press
        reset = 1'b0;
        press(8);
        release_key(100);
        exp_q.push_back("E"); exp_q.push_back(" ");
        check_stream("held_through_reset");

        // Single dot: E after the letter gap, then exactly one space 4 units later
        press(5);
        release_key(45);
        check("e_before_space", got.size(), 1);
        release_key(60);
        check("e_space_delta", (got_t.size() == 2) ? got_t[1] - got_t[0] : -1, int'(4 * U));
        exp_q.push_back("E"); exp_q.push_back(" ");
        check_stream("letter_e");

        // B: dash-dot-dot-dot with elem_count stepping up, then clearing
        press(30); release_key(10); check("b_cnt1", int'(bus.elem_count), 1); release_key(5);
        press(5);  release_key(10); check("b_cnt2", int'(bus.elem_count), 2); release_key(5);
        press(5);  release_key(10); check("b_cnt3", int'(bus.elem_count), 3); release_key(5);
        press(5);  release_key(10); check("b_cnt4", int'(bus.elem_count), 4);
        release_key(35);
        check("b_cnt_clear", int'(bus.elem_count), 0);
        release_key(55);
        exp_q.push_back("B"); exp_q.push_back(" ");
        check_stream("letter_b");

        // Six dots: count saturates at five and the letter decodes as '?'
        for (int i = 0; i < 6; i++) begin
            press(5);
            release_key(10);
            if (i >= 4) check("ovf_cnt_sat", int'(bus.elem_count), 5);
            release_key(5);
        end
        release_key(90);
        exp_q.push_back("?"); exp_q.push_back(" ");
        check_stream("overflow");

        // Short glitch never reaches the debounced key
        kd_seen = 0;
        press(2);
        release_key(100);
        check("glitch_key_down", kd_seen, 0);
        check_stream("glitch");

        // Reset in the middle of S discards the partial letter
        press(5); release_key(15);
        press(5); release_key(15);
        press(3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        release_key(100);
        check("rst_mid_elem_count", int'(bus.elem_count), 0);
        check_stream("reset_mid_letter");

        // E, 50-cycle gap, E: the second letter cancels the pending space
        press(5);
        release_key(50);
        press(5);
        release_key(100);
        exp_q.push_back("E"); exp_q.push_back("E"); exp_q.push_back(" ");
        check_stream("no_space_between");

        // Random words: letter gaps between 3 and 7 units, word gaps beyond 7
        for (int w = 0; w < 6; w++) begin
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                idx = int'($urandom_range(0, 37));
                send_pattern(morse_tab[idx]);
                exp_q.push_back(sym_char(idx));
                if (l == nl - 1) begin
                    release_key(int'($urandom_range(90, 120)));
                    exp_q.push_back(" ");
                end else begin
                    release_key(int'($urandom_range(38, 55)));
                end
            end
        end
        check_stream("random_text");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
